// File: rtl/spiflash_target_wb.sv
// SPI-flash target emulator: serves READ (0x03) from an image RAM that the SoC fills over Wishbone.
// Optional build macro SPIFLASHTGT_FASTREAD_EN adds FAST READ (0x0B) with 8 dummy clocks.
module spiflash_target_wb #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   input  logic        ss,
   input  logic        sck,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   output logic        busy
);
   localparam int WW = $clog2(DEPTH_WORDS);
   localparam int AW = WW + 2;

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGNORE} state_t;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [31:0]   spi_word_q;
   logic          wb_ack_q;
   logic [31:0]   wb_dat_q;
   logic [1:0]    ss_sync_q, sck_sync_q, mosi_sync_q;
   logic          sck_prev_q;
   state_t        state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [22:0]   sr_q, sr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          fetch_q, fetch_d;
   logic [7:0]    sh_q, sh_d;
   logic          miso_q, miso_d;
   logic          fast_q, fast_d;

   logic          ss_s, sck_s, mosi_s, sck_rise, sck_fall, wb_valid;
   logic [WW-1:0] wb_idx;
   logic [23:0]   bit_in;
   logic [7:0]    cur_byte;
   logic          unused_ok;

   assign ss_s     = ss_sync_q[1];
   assign sck_s    = sck_sync_q[1];
   assign mosi_s   = mosi_sync_q[1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign wb_valid = wb_cyc_i & wb_stb_i & ~wb_ack_q;
   assign wb_idx   = wb_adr_i[AW-1:2];
   assign bit_in   = {sr_q, mosi_s};
   assign cur_byte = spi_word_q[{addr_q[1:0], 3'b000} +: 8];
   assign unused_ok = ^{wb_adr_i[31:AW], wb_adr_i[1:0], bit_in[23:AW]};

   // Dual-port image: a same-cycle WB write and SPI fetch gives SPI the old data.
   always_ff @(posedge wb_clk_i) begin
      if (wb_valid && wb_we_i)
         for (int k = 0; k < 4; k++)
            if (wb_sel_i[k]) mem[wb_idx][8*k +: 8] <= wb_dat_i[8*k +: 8];
      if (fetch_q) spi_word_q <= mem[addr_q[AW-1:2]];
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb_ack_q    <= 1'b0;
         wb_dat_q    <= '0;
         ss_sync_q   <= 2'b11;
         sck_sync_q  <= 2'b00;
         mosi_sync_q <= 2'b00;
         sck_prev_q  <= 1'b0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sr_q        <= '0;
         addr_q      <= '0;
         fetch_q     <= 1'b0;
         sh_q        <= '0;
         miso_q      <= 1'b0;
         fast_q      <= 1'b0;
      end else begin
         wb_ack_q    <= wb_valid;
         if (wb_valid && !wb_we_i) wb_dat_q <= mem[wb_idx];
         ss_sync_q   <= {ss_sync_q[0], ss};
         sck_sync_q  <= {sck_sync_q[0], sck};
         mosi_sync_q <= {mosi_sync_q[0], mosi};
         sck_prev_q  <= sck_s;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         addr_q      <= addr_d;
         fetch_q     <= fetch_d;
         sh_q        <= sh_d;
         miso_q      <= miso_d;
         fast_q      <= fast_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      addr_d  = addr_q;
      fetch_d = 1'b0;
      sh_d    = sh_q;
      miso_d  = miso_q;
      fast_d  = fast_q;
      if (ss_s) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         fast_d  = 1'b0;
         miso_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_CMD;
               cnt_d   = '0;
            end
            S_CMD: if (sck_rise) begin
               sr_d  = bit_in[22:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  cnt_d = '0;
                  if (bit_in[7:0] == 8'h03) state_d = S_ADDR;
`ifdef SPIFLASHTGT_FASTREAD_EN
                  else if (bit_in[7:0] == 8'h0B) begin
                     state_d = S_ADDR;
                     fast_d  = 1'b1;
                  end
`endif
                  else state_d = S_IGNORE;
               end
            end
            S_ADDR: if (sck_rise) begin
               sr_d  = bit_in[22:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd23) begin
                  cnt_d   = '0;
                  addr_d  = bit_in[AW-1:0];
                  fetch_d = 1'b1;
                  state_d = fast_q ? S_DUMMY : S_DATA;
               end
            end
            S_DUMMY: begin
               if (sck_fall) miso_d = 1'b0;
               if (sck_rise) begin
                  cnt_d = cnt_q + 5'd1;
                  if (cnt_q == 5'd7) begin
                     cnt_d   = '0;
                     state_d = S_DATA;
                  end
               end
            end
            S_DATA: begin
               // cnt_q[2:0]==0 on a fall means the previous byte is done: load the prefetched one.
               if (sck_fall) begin
                  if (cnt_q[2:0] == 3'd0) begin
                     miso_d = cur_byte[7];
                     sh_d   = {cur_byte[6:0], 1'b0};
                  end else begin
                     miso_d = sh_q[7];
                     sh_d   = {sh_q[6:0], 1'b0};
                  end
               end
               if (sck_rise) begin
                  cnt_d = {2'b00, cnt_q[2:0] + 3'd1};
                  if (cnt_q[2:0] == 3'd0) begin
                     addr_d  = addr_q + 1'b1;
                     fetch_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign wb_ack_o = wb_ack_q;
   assign wb_dat_o = wb_dat_q;
   assign miso     = miso_q;
   assign miso_oe  = ~ss_s & ((state_q == S_DATA) || (state_q == S_DUMMY));
   assign busy     = ~ss_s;
endmodule

// File: tb/tb_spiflash_target_wb.sv
// Directed bench for spiflash_target_wb: Wishbone image load/readback and SPI READ sequences.
module tb_spiflash_target_wb;
   localparam int H = 16;  // sck half period in clk cycles

   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] adr = '0, dat_w = '0, dat_r;
   logic [3:0]  sel = '0;
   logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, ack;
   logic        ss = 1'b1, sck = 1'b0, mosi = 1'b0, miso, miso_oe, busy;

   int          n_cmp = 0, n_bad = 0;
   logic        oe_and, oe_or, busy_and;
   logic [7:0]  rx;

   always #5 clk = ~clk;

   spiflash_target_wb #(.DEPTH_WORDS(1024)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack),
      .ss(ss), .sck(sck), .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
      @(negedge clk);
      adr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("wb_ack_hi", {31'b0, ack}, 32'd1);
      rd = dat_r;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      chk("wb_ack_lo", {31'b0, ack}, 32'd0);
   endtask

   task automatic spi_bit(input logic b, output logic r);
      mosi = b;
      repeat (H) @(negedge clk);
      r = miso;
      oe_and &= miso_oe;
      oe_or  |= miso_oe;
      busy_and &= busy;
      sck = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
      for (int i = 7; i >= 0; i--) spi_bit(tx[i], r[i]);
   endtask

   task automatic ss_lo();
      @(negedge clk);
      ss = 1'b0;
      repeat (H) @(negedge clk);
   endtask

   task automatic ss_hi();
      repeat (H) @(negedge clk);
      ss = 1'b1;
      repeat (4) @(negedge clk);
      chk("oe_after_ss", {31'b0, miso_oe}, 32'd0);
      chk("busy_after_ss", {31'b0, busy}, 32'd0);
      repeat (H) @(negedge clk);
   endtask

   task automatic spi_cmd(input logic [7:0] c, input logic [23:0] a);
      logic [7:0] d;
      ss_lo();
      spi_byte(c, d);
      spi_byte(a[23:16], d);
      spi_byte(a[15:8], d);
      spi_byte(a[7:0], d);
   endtask

   task automatic read_expect(input string tag, input logic [7:0] e0, input logic [7:0] e1);
      oe_and = 1'b1; oe_or = 1'b0;
      spi_byte(8'h00, rx); chk({tag, "_b0"}, {24'b0, rx}, {24'b0, e0});
      spi_byte(8'h00, rx); chk({tag, "_b1"}, {24'b0, rx}, {24'b0, e1});
      chk({tag, "_oe"}, {31'b0, oe_and}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        b;
      repeat (3) @(negedge clk);
      chk("rst_ack", {31'b0, ack}, 32'd0);
      chk("rst_dat", dat_r, 32'd0);
      chk("rst_miso", {31'b0, miso}, 32'd0);
      chk("rst_oe", {31'b0, miso_oe}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Image load and readback, including byte enables and ignored upper address bits
      wb_xfer(32'h0000_0000, 1'b1, 32'h4433_2211, 4'hF, rd);
      wb_xfer(32'h0000_0004, 1'b1, 32'h8877_6655, 4'hF, rd);
      wb_xfer(32'h0000_0FFC, 1'b1, 32'hDDCC_BBAA, 4'hF, rd);
      wb_xfer(32'h0000_0008, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
      wb_xfer(32'h1000_0008, 1'b1, 32'h0000_00AB, 4'h1, rd);
      wb_xfer(32'h0000_0000, 1'b0, 32'h0, 4'h0, rd);
      chk("wb_rd_w0", rd, 32'h4433_2211);
      wb_xfer(32'h0000_0008, 1'b0, 32'h0, 4'h0, rd);
      chk("wb_rd_sel", rd, 32'hFFFF_FFAB);
      wb_xfer(32'h0000_0FFC, 1'b0, 32'h0, 4'h0, rd);
      chk("wb_rd_top", rd, 32'hDDCC_BBAA);

      // Plain READ at 0: 11 22 33 44
      busy_and = 1'b1;
      spi_cmd(8'h03, 24'h000000);
      chk("busy_during", {31'b0, busy_and}, 32'd1);
      read_expect("rd0", 8'h11, 8'h22);
      read_expect("rd0n", 8'h33, 8'h44);
      ss_hi();

      // Wrap from the last byte back to 0
      spi_cmd(8'h03, 24'h000FFE);
      read_expect("wrap", 8'hCC, 8'hDD);
      read_expect("wrapn", 8'h11, 8'h22);
      ss_hi();

      // Unknown command stays tri-stated, next READ is clean
      spi_cmd(8'h9F, 24'h000000);
      oe_or = 1'b0;
      spi_byte(8'h00, rx);
      chk("ign_oe", {31'b0, oe_or}, 32'd0);
      ss_hi();
      spi_cmd(8'h03, 24'h000004);
      read_expect("after_ign", 8'h55, 8'h66);
      ss_hi();

      // Abort after 12 address bits, then a fresh READ at 1
      ss_lo();
      spi_byte(8'h03, rx);
      for (int i = 0; i < 12; i++) spi_bit(1'b1, b);
      ss_hi();
      spi_cmd(8'h03, 24'h000001);
      read_expect("abort", 8'h22, 8'h33);
      ss_hi();

      // FAST READ
      spi_cmd(8'h0B, 24'h000000);
`ifdef SPIFLASHTGT_FASTREAD_EN
      oe_and = 1'b1;
      spi_byte(8'h00, rx);
      chk("dummy_miso", {24'b0, rx}, 32'h0);
      chk("dummy_oe", {31'b0, oe_and}, 32'd1);
      read_expect("fast", 8'h11, 8'h22);
`else
      oe_or = 1'b0;
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      chk("fast_off_oe", {31'b0, oe_or}, 32'd0);
`endif
      ss_hi();

      // Reset mid-transfer keeps the image
      spi_cmd(8'h03, 24'h000000);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("midrst_oe", {31'b0, miso_oe}, 32'd0);
      chk("midrst_miso", {31'b0, miso}, 32'd0);
      ss = 1'b1; rst = 1'b0;
      repeat (4) @(negedge clk);
      wb_xfer(32'h0000_0004, 1'b0, 32'h0, 4'h0, rd);
      chk("midrst_ram", rd, 32'h8877_6655);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
